// File: rtl/vls_pkg.sv
// Shared types and constants for the vector load/store sequencer.
package vls_pkg;

   localparam int unsigned DW          = 32;
   localparam int unsigned AW          = 32;
   localparam int unsigned NUM_ELEM    = 8;
   localparam int unsigned RF_VBASE    = 8;
   localparam int unsigned ELEM_STRIDE = 4;
   localparam int unsigned IW          = 3;   // element index width
   localparam int unsigned NW          = 4;   // element count width (0..NUM_ELEM)

   typedef enum logic [2:0] {
      IDLE,
      S_RD,
      S_REQ,
      L_REQ,
      COMMIT,
      FIN
   } state_t;

   // Element count for a requested vector length: zero stays zero, large values clip.
   function automatic logic [NW-1:0] elem_count(input logic [31:0] vlen);
      if (vlen > 32'(NUM_ELEM)) return NW'(NUM_ELEM);
      return NW'(vlen);
   endfunction

endpackage

// File: rtl/vls_sequencer.sv
// Vector load/store sequencer: steps the regfile vector banks against data memory,
// one element per memory transaction, with a registered load buffer committed in one pulse.
module vls_sequencer
   import vls_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   is_store,
   input  logic [1:0]             vreg_idx,
   input  logic [AW-1:0]          base_addr,
   input  logic [31:0]            vlen,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [4:0]             rf_cnt,
   output logic [4:0]             rf_raddr2,
   input  logic [DW-1:0]          rf_rdata,
   output logic                   rf_vwrite,
   output logic [4:0]             rf_vaddr,
   output logic [NUM_ELEM*DW-1:0] rf_vdata,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [AW-1:0]          mem_addr,
   output logic [DW-1:0]          mem_wdata,
   input  logic                   mem_ack,
   input  logic [DW-1:0]          mem_rdata
);

   state_t                 state, state_nx;
   logic [1:0]             vidx_q, vidx_nx;
   logic [AW-1:0]          base_q, base_nx;
   logic [NW-1:0]          n_q, n_nx, n_in;
   logic [IW-1:0]          i_q, i_nx;
   logic                   err_lat, err_lat_nx;
   logic [NUM_ELEM*DW-1:0] vbuf, vbuf_nx;

   logic                   busy_nx, done_nx, err_nx, rf_vwrite_nx, mem_req_nx, mem_we_nx;
   logic [4:0]             rf_cnt_nx, rf_raddr2_nx, rf_vaddr_nx;
   logic [AW-1:0]          mem_addr_nx;
   logic [DW-1:0]          mem_wdata_nx;
   logic                   last, store_phase;

   assign rf_vdata = vbuf;

   // Next state, datapath updates, and next values of the registered outputs.
   always_comb begin
      state_nx     = state;
      vidx_nx      = vidx_q;
      base_nx      = base_q;
      n_nx         = n_q;
      i_nx         = i_q;
      err_lat_nx   = err_lat;
      vbuf_nx      = vbuf;
      mem_wdata_nx = mem_wdata;
      n_in         = elem_count(vlen);
      last         = ({1'b0, i_q} == (n_q - NW'(1)));

      case (state)
         IDLE: begin
            if (start) begin
               vidx_nx    = vreg_idx;
               base_nx    = base_addr;
               n_nx       = n_in;
               i_nx       = '0;
               err_lat_nx = (vreg_idx == 2'd3);
               if (vreg_idx == 2'd3 || n_in == '0) begin
                  state_nx = FIN;
               end else if (is_store) begin
                  state_nx = S_RD;
               end else begin
                  vbuf_nx  = '0;
                  state_nx = L_REQ;
               end
            end
         end
         S_RD: begin
            mem_wdata_nx = rf_rdata;
            state_nx     = S_REQ;
         end
         S_REQ: begin
            if (mem_ack) begin
               if (last) begin
                  state_nx = FIN;
               end else begin
                  i_nx     = i_q + IW'(1);
                  state_nx = S_RD;
               end
            end
         end
         L_REQ: begin
            if (mem_ack) begin
               vbuf_nx[32'(i_q)*DW +: DW] = mem_rdata;
               if (last) state_nx = COMMIT;
               else      i_nx     = i_q + IW'(1);
            end
         end
         COMMIT:  state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // Outputs are decoded from the next state so they line up with the state register.
      store_phase  = (state_nx == S_RD) || (state_nx == S_REQ);
      busy_nx      = (state_nx != IDLE);
      done_nx      = (state_nx == FIN);
      err_nx       = (state_nx == FIN) && err_lat_nx;
      rf_cnt_nx    = store_phase ? (5'(i_nx) + 5'd1) : 5'd0;
      rf_raddr2_nx = store_phase ? 5'(RF_VBASE + NUM_ELEM * 32'(vidx_nx)) : 5'd0;
      rf_vwrite_nx = (state_nx == COMMIT);
      rf_vaddr_nx  = (state_nx == COMMIT) ? 5'(vidx_nx) : 5'd0;
      mem_req_nx   = (state_nx == S_REQ) || (state_nx == L_REQ);
      mem_we_nx    = (state_nx == S_REQ);
      mem_addr_nx  = mem_req_nx ? (base_nx + AW'(ELEM_STRIDE) * AW'(i_nx)) : '0;
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         vidx_q    <= '0;
         base_q    <= '0;
         n_q       <= '0;
         i_q       <= '0;
         err_lat   <= 1'b0;
         vbuf      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         rf_cnt    <= '0;
         rf_raddr2 <= '0;
         rf_vwrite <= 1'b0;
         rf_vaddr  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_nx;
         vidx_q    <= vidx_nx;
         base_q    <= base_nx;
         n_q       <= n_nx;
         i_q       <= i_nx;
         err_lat   <= err_lat_nx;
         vbuf      <= vbuf_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         err       <= err_nx;
         rf_cnt    <= rf_cnt_nx;
         rf_raddr2 <= rf_raddr2_nx;
         rf_vwrite <= rf_vwrite_nx;
         rf_vaddr  <= rf_vaddr_nx;
         mem_req   <= mem_req_nx;
         mem_we    <= mem_we_nx;
         mem_addr  <= mem_addr_nx;
         mem_wdata <= mem_wdata_nx;
      end
   end

endmodule

// File: tb/tb_vls_sequencer.sv
// Self-checking bench for vls_sequencer: randomized vector loads/stores against a
// list-level reference model of memory traffic, commit contents and completion timing.
module tb_vls_sequencer;
   import vls_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst, start, is_store;
   logic [1:0]             vreg_idx;
   logic [AW-1:0]          base_addr;
   logic [31:0]            vlen;
   logic                   busy, done, err;
   logic [4:0]             rf_cnt, rf_raddr2, rf_vaddr;
   logic [DW-1:0]          rf_rdata;
   logic                   rf_vwrite;
   logic [NUM_ELEM*DW-1:0] rf_vdata;
   logic                   mem_req, mem_we;
   logic [AW-1:0]          mem_addr;
   logic [DW-1:0]          mem_wdata;
   logic                   mem_ack = 1'b0;
   logic [DW-1:0]          mem_rdata = '0;

   vls_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .is_store(is_store), .vreg_idx(vreg_idx),
      .base_addr(base_addr), .vlen(vlen), .busy(busy), .done(done), .err(err),
      .rf_cnt(rf_cnt), .rf_raddr2(rf_raddr2), .rf_rdata(rf_rdata), .rf_vwrite(rf_vwrite),
      .rf_vaddr(rf_vaddr), .rf_vdata(rf_vdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Regfile: element cnt-1 of the bank addressed by read_addr2.
   logic [DW-1:0] gpr [32];
   wire  [4:0]    rd_idx = rf_raddr2 + rf_cnt - 5'd1;
   assign rf_rdata = gpr[rd_idx];

   // Data memory image plus transaction logs.
   bit [31:0]              mem_img [bit [31:0]];
   logic [AW-1:0]          wr_addr [$];
   logic [DW-1:0]          wr_data [$];
   logic [4:0]             wr_cnt  [$];
   logic [AW-1:0]          rd_addr [$];
   logic [NUM_ELEM*DW-1:0] vw_data [$];
   logic [4:0]             vw_addr [$];
   int ack_delay = 0, wait_cnt = 0, done_cnt = 0, req_cycles = 0;
   int obs_lat;
   logic obs_err, obs_busy1;

   // Memory responder and monitor: ack after ack_delay waiting cycles per request.
   always @(negedge clk) begin
      if (rf_vwrite) begin vw_data.push_back(rf_vdata); vw_addr.push_back(rf_vaddr); end
      if (done) done_cnt++;
      if (mem_req) req_cycles++;
      if (mem_req && !rst) begin
         if (wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr] : ~mem_addr;
            wait_cnt  = 0;
            if (mem_we) begin
               wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata); wr_cnt.push_back(rf_cnt);
            end else begin
               rd_addr.push_back(mem_addr);
            end
         end else begin
            mem_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end
   end

   function automatic int exp_n(input logic [31:0] vl);
      if (vl > 32'd8) return 8;
      return int'(vl);
   endfunction

   task automatic clear_logs();
      wr_addr.delete(); wr_data.delete(); wr_cnt.delete(); rd_addr.delete();
      vw_data.delete(); vw_addr.delete();
      done_cnt = 0; req_cycles = 0;
   endtask

   // Issue one operation; xs>0 pulses a conflicting start at that cycle while busy.
   task automatic run_op(input bit st, input logic [1:0] v, input logic [31:0] b,
                         input logic [31:0] vl, input int dly, input int xs);
      clear_logs();
      ack_delay = dly;
      obs_lat   = -1;
      obs_err   = 1'b0;
      @(negedge clk);
      start = 1'b1; is_store = st; vreg_idx = v; base_addr = b; vlen = vl;
      @(negedge clk);
      start     = 1'b0;
      obs_busy1 = busy;
      for (int c = 1; c <= 400; c++) begin
         if (done) begin obs_lat = c; obs_err = err; break; end
         if (c == xs) begin
            start = 1'b1; is_store = ~st; vreg_idx = 2'd0; base_addr = b ^ 32'h1000; vlen = 32'd8;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, err, rf_cnt, rf_raddr2, rf_vwrite, rf_vaddr, mem_req, mem_we} !== '0 ||
          mem_addr !== '0 || mem_wdata !== '0 || rf_vdata !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b mem_req=%b rf_cnt=%0d vdata_nz=%b, all required 0",
                  busy, done, mem_req, rf_cnt, rf_vdata != '0);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store();
      logic [1:0] v; logic [31:0] b, vl; int d, n, el;
      for (int t = 0; t < 8; t++) begin
         if (t == 0)      begin v = 2'd1; b = 32'h100;      vl = 32'd3; d = 0; end
         else if (t == 1) begin v = 2'd0; b = 32'hFFFFFFFC; vl = 32'd2; d = 0; end
         else begin
            v  = 2'($urandom_range(0, 2));
            b  = $urandom & 32'hFFFF_FFFC;
            vl = (t == 7) ? 32'h8000_0000 : 32'($urandom_range(1, 12));
            d  = $urandom_range(0, 2);
         end
         n  = exp_n(vl);
         el = n * (2 + d) + 1;
         run_op(1'b1, v, b, vl, d, 0);
         checks++;
         if (obs_lat !== el || obs_err !== 1'b0 || done_cnt !== 1 || obs_busy1 !== 1'b1) begin
            errors++;
            $display("FAIL store_done[%0d]: lat=%0d err=%b dones=%0d busy=%b, required lat=%0d err=0 dones=1 busy=1",
                     t, obs_lat, obs_err, done_cnt, obs_busy1, el);
         end
         checks++;
         if (wr_addr.size() !== n || rd_addr.size() !== 0 || vw_data.size() !== 0) begin
            errors++;
            $display("FAIL store_count[%0d]: writes=%0d reads=%0d commits=%0d, required %0d/0/0",
                     t, wr_addr.size(), rd_addr.size(), vw_data.size(), n);
         end
         for (int k = 0; k < n && k < wr_addr.size(); k++) begin
            checks++;
            if (wr_addr[k] !== b + 32'(4 * k) || wr_data[k] !== gpr[RF_VBASE + NUM_ELEM * v + k] ||
                wr_cnt[k] !== 5'(k + 1)) begin
               errors++;
               $display("FAIL store_elem[%0d.%0d]: addr=%h data=%h cnt=%0d, required addr=%h data=%h cnt=%0d",
                        t, k, wr_addr[k], wr_data[k], wr_cnt[k], b + 32'(4 * k),
                        gpr[RF_VBASE + NUM_ELEM * v + k], k + 1);
            end
         end
      end
   endtask

   task automatic test_load();
      logic [1:0] v; logic [31:0] b, vl; int d, n, el;
      logic [NUM_ELEM*DW-1:0] ev;
      for (int t = 0; t < 8; t++) begin
         if (t == 0)      begin v = 2'd2; b = 32'h400; vl = 32'd8;  d = 2; end
         else if (t == 1) begin v = 2'd0; b = 32'h800; vl = 32'd20; d = 0; end
         else if (t == 2) begin v = 2'd1; b = 32'h900; vl = 32'd2;  d = 1; end
         else begin
            v  = 2'($urandom_range(0, 2));
            b  = $urandom & 32'hFFFF_FFFC;
            vl = 32'($urandom_range(1, 10));
            d  = $urandom_range(0, 3);
         end
         for (int k = 0; k < 12; k++) mem_img[b + 32'(4 * k)] = (t == 0) ? 32'(32'hA0 + k) : $urandom;
         n  = exp_n(vl);
         el = n * (1 + d) + 2;
         ev = '0;
         for (int k = 0; k < n; k++) ev[k*DW +: DW] = mem_img[b + 32'(4 * k)];
         run_op(1'b0, v, b, vl, d, 0);
         checks++;
         if (obs_lat !== el || obs_err !== 1'b0 || done_cnt !== 1 || obs_busy1 !== 1'b1) begin
            errors++;
            $display("FAIL load_done[%0d]: lat=%0d err=%b dones=%0d busy=%b, required lat=%0d err=0 dones=1 busy=1",
                     t, obs_lat, obs_err, done_cnt, obs_busy1, el);
         end
         checks++;
         if (rd_addr.size() !== n || wr_addr.size() !== 0 || vw_data.size() !== 1) begin
            errors++;
            $display("FAIL load_count[%0d]: reads=%0d writes=%0d commits=%0d, required %0d/0/1",
                     t, rd_addr.size(), wr_addr.size(), vw_data.size(), n);
         end
         for (int k = 0; k < n && k < rd_addr.size(); k++) begin
            checks++;
            if (rd_addr[k] !== b + 32'(4 * k)) begin
               errors++;
               $display("FAIL load_addr[%0d.%0d]: got %h required %h", t, k, rd_addr[k], b + 32'(4 * k));
            end
         end
         if (vw_data.size() > 0) begin
            checks++;
            if (vw_data[0] !== ev || vw_addr[0] !== 5'(v)) begin
               errors++;
               $display("FAIL load_commit[%0d]: vaddr=%0d data=%h, required vaddr=%0d data=%h",
                        t, vw_addr[0], vw_data[0], v, ev);
            end
         end
      end
   endtask

   task automatic test_empty_err();
      bit st; logic [1:0] v; logic [31:0] vl; logic ee;
      for (int t = 0; t < 4; t++) begin
         st = t[0];
         v  = (t < 2) ? 2'($urandom_range(0, 2)) : 2'd3;
         vl = (t < 2) ? 32'd0 : 32'd5;
         ee = (t >= 2);
         run_op(st, v, 32'h40, vl, 0, 0);
         checks++;
         if (obs_lat !== 1 || obs_err !== ee || done_cnt !== 1 || req_cycles !== 0 || vw_data.size() !== 0) begin
            errors++;
            $display("FAIL empty_err[%0d]: lat=%0d err=%b dones=%0d req_cycles=%0d commits=%0d, required 1/%b/1/0/0",
                     t, obs_lat, obs_err, done_cnt, req_cycles, vw_data.size(), ee);
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic [NUM_ELEM*DW-1:0] ev;
      ev = '0;
      for (int k = 0; k < 8; k++) mem_img[32'h2000 + 32'(4 * k)] = $urandom;
      for (int k = 0; k < 4; k++) ev[k*DW +: DW] = mem_img[32'h2000 + 32'(4 * k)];
      run_op(1'b0, 2'd1, 32'h2000, 32'd4, 1, 3);
      checks++;
      if (obs_lat !== 10 || done_cnt !== 1 || rd_addr.size() !== 4 || wr_addr.size() !== 0) begin
         errors++;
         $display("FAIL busy_ignore: lat=%0d dones=%0d reads=%0d writes=%0d, required 10/1/4/0",
                  obs_lat, done_cnt, rd_addr.size(), wr_addr.size());
      end
      if (vw_data.size() > 0) begin
         checks++;
         if (vw_data[0] !== ev || vw_addr[0] !== 5'd1) begin
            errors++;
            $display("FAIL busy_ignore_commit: vaddr=%0d data=%h, required vaddr=1 data=%h",
                     vw_addr[0], vw_data[0], ev);
         end
      end
   endtask

   task automatic test_reset_abort();
      bit seen;
      for (int t = 0; t < 2; t++) begin
         clear_logs();
         ack_delay = 1000;
         seen      = 1'b0;
         @(negedge clk);
         start = 1'b1; is_store = (t == 0); vreg_idx = 2'd0; base_addr = 32'h500; vlen = 32'd4;
         @(negedge clk);
         start = 1'b0;
         for (int c = 0; c < 20; c++) begin
            if (mem_req) begin seen = 1'b1; break; end
            @(negedge clk);
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL abort_req_timeout[%0d]: mem_req=0 after 20 cycles, required 1", t);
         end
         rst = 1'b1;
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b0 || busy !== 1'b0 || rf_cnt !== 5'd0) begin
            errors++;
            $display("FAIL abort_now[%0d]: mem_req=%b busy=%b rf_cnt=%0d, required 0/0/0",
                     t, mem_req, busy, rf_cnt);
         end
         rst = 1'b0;
         repeat (10) @(negedge clk);
         checks++;
         if (done_cnt !== 0 || vw_data.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet[%0d]: dones=%0d commits=%0d busy=%b, required 0/0/0",
                     t, done_cnt, vw_data.size(), busy);
         end
      end
      run_op(1'b1, 2'd2, 32'h600, 32'd2, 0, 0);
      checks++;
      if (obs_lat !== 5 || wr_addr.size() !== 2 || done_cnt !== 1) begin
         errors++;
         $display("FAIL abort_recover: lat=%0d writes=%0d dones=%0d, required 5/2/1",
                  obs_lat, wr_addr.size(), done_cnt);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_store = 1'b0; vreg_idx = '0; base_addr = '0; vlen = '0;
      for (int k = 0; k < 32; k++) gpr[k] = $urandom;
      test_reset();
      test_store();
      test_load();
      test_empty_err();
      test_busy_ignore();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
